// File: rtl/ema_filter_mc_if.sv
// ema_filter_mc_if: sample-in / result-out bus of the multi-channel EMA filter.
//   in_valid/in_ready/in_ch/x_in/alpha_shift : sample handshake and payload
//   flush                                    : one-cycle pulse, un-seeds all channels
//   out_valid/out_ready/out_ch/y_out         : result handshake and payload
//   err_ch                                   : sticky invalid-channel flag
// master = sample source / result consumer side, slave = filter side.
interface ema_filter_mc_if #(
    parameter int W  = 8,
    parameter int CW = 2,
    parameter int KW = 3
);
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ch;
    logic [W-1:0]  x_in;
    logic [KW-1:0] alpha_shift;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ch;
    logic [W-1:0]  y_out;
    logic          err_ch;

    modport master (
        output in_valid, in_ch, x_in, alpha_shift, flush, out_ready,
        input  in_ready, out_valid, out_ch, y_out, err_ch
    );

    modport slave (
        input  in_valid, in_ch, x_in, alpha_shift, flush, out_ready,
        output in_ready, out_valid, out_ch, y_out, err_ch
    );
endinterface

// File: rtl/ema_filter_mc.sv
// ema_filter_mc: time-multiplexed exponential moving average, y += (x - y) * 2^-k,
// for CH interleaved channels. Each channel keeps a W+F bit accumulator and a
// seeded flag; the first sample of a channel (or any sample with k == 0) loads
// the accumulator directly. One output register with valid/ready backpressure.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : ema_filter_mc_if slave modport (sample in, result out, flush, err_ch)
module ema_filter_mc #(
    parameter int W    = 8,
    parameter int F    = 8,
    parameter int CH   = 4,
    parameter int KMAX = 7
) (
    input  logic           clk,
    input  logic           reset,
    ema_filter_mc_if.slave bus
);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;
    localparam int KW = $clog2(KMAX + 1);
    localparam int AW = W + F;

    logic [AW-1:0]        acc_r [CH];
    logic [CH-1:0]        seeded_r;
    logic                 out_valid_r;
    logic [CW-1:0]        out_ch_r;
    logic [W-1:0]         y_r;
    logic                 err_r;

    logic                 in_ready_s;
    logic                 accept_s;
    logic                 ch_bad_s;
    logic                 load_s;
    logic                 use_seed_s;
    logic [KW-1:0]        k_s;
    logic [AW-1:0]        acc_cur_s;
    logic [AW-1:0]        xs_s;
    logic [AW-1:0]        acc_next_s;
    logic signed [AW:0]   diff_s;
    logic signed [AW:0]   step_s;
    logic signed [AW:0]   sum_s;
    logic [AW:0]          rnd_s;
    logic [W:0]           y_full_s;
    logic [W-1:0]         y_s;

    // Channel range check only exists when the index field can encode more than CH values.
    if ((1 << CW) > CH) begin : g_chk
        assign ch_bad_s = (bus.in_ch >= CW'(CH));
    end else begin : g_nochk
        assign ch_bad_s = 1'b0;
    end

    // Shift clamp only exists when alpha_shift can encode values above KMAX.
    if (KMAX < (1 << KW) - 1) begin : g_clamp
        assign k_s = (bus.alpha_shift > KW'(KMAX)) ? KW'(KMAX) : bus.alpha_shift;
    end else begin : g_noclamp
        assign k_s = bus.alpha_shift;
    end

    // Single output register: a new sample may enter whenever the register is free or draining.
    assign in_ready_s = !out_valid_r || bus.out_ready;
    assign accept_s   = bus.in_valid && in_ready_s;
    assign load_s     = accept_s && !ch_bad_s;

    // Filter arithmetic for the channel addressed by the incoming sample.
    always_comb begin
        acc_cur_s  = acc_r[bus.in_ch];
        xs_s       = {bus.x_in, {F{1'b0}}};
        // A coincident flush un-seeds the channel before this sample is applied.
        use_seed_s = !seeded_r[bus.in_ch] || bus.flush || (k_s == {KW{1'b0}});
        diff_s     = $signed({1'b0, xs_s}) - $signed({1'b0, acc_cur_s});
        // Arithmetic shift floors toward minus infinity, so a falling input converges exactly.
        step_s     = diff_s >>> k_s;
        sum_s      = $signed({1'b0, acc_cur_s}) + step_s;
        if (use_seed_s) begin
            acc_next_s = xs_s;
        end else begin
            // Result always lies between acc and xs, so the top bit is never needed.
            acc_next_s = AW'(sum_s);
        end
        rnd_s    = {1'b0, acc_next_s} + ((AW + 1)'(1) << (F - 1));
        y_full_s = (W + 1)'(rnd_s >> F);
        if (y_full_s[W]) begin
            y_s = {W{1'b1}};
        end else begin
            y_s = y_full_s[W-1:0];
        end
    end

    // Channel state, sticky error flag and output register update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CH; i++) begin
                acc_r[i] <= {AW{1'b0}};
            end
            seeded_r    <= {CH{1'b0}};
            out_valid_r <= 1'b0;
            out_ch_r    <= {CW{1'b0}};
            y_r         <= {W{1'b0}};
            err_r       <= 1'b0;
        end else begin
            if (bus.flush) begin
                seeded_r <= {CH{1'b0}};
            end
            // Later assignment wins, so a sample coincident with flush leaves its channel seeded.
            if (load_s) begin
                acc_r[bus.in_ch]    <= acc_next_s;
                seeded_r[bus.in_ch] <= 1'b1;
            end
            if (accept_s && ch_bad_s) begin
                err_r <= 1'b1;
            end
            if (load_s) begin
                out_valid_r <= 1'b1;
                out_ch_r    <= bus.in_ch;
                y_r         <= y_s;
            end else if (bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_ch    = out_ch_r;
    assign bus.y_out     = y_r;
    assign bus.err_ch    = err_r;
endmodule
